// File: rtl/sb_config_loader.sv
// Purpose : programs a chain of switch-box tiles by serialising a word stream
//           LSB-first onto prog_in/prog_en. Optionally reads the chain back
//           by recirculating prog_out into prog_in, and compares the CRC-8.
// Latency : the first chain shift is 2 cycles after the first handshake.
//           Loads run back-to-back while s_valid stays high. done pulses
//           1 cycle after the last load shift, or 1 cycle after a readback
//           of CHAIN_LEN cycles.
// Backpr. : s_ready is high only in LOAD, and only while the 1-word holding
//           register is empty and fewer than NW words have been taken.
// Ports   : i_prog_clk/i_prog_rst_n - clock and async active-low reset
//           i_start/i_verify        - operation request; verify selects readback
//           i_s_data/i_s_valid/o_s_ready - configuration word stream
//           o_prog_in/o_prog_en/i_prog_out - tile chain head, enable and tail
//           o_busy/o_done/o_err/o_crc - status, end pulse, readback error, CRC-8
module sb_config_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              i_prog_clk,
  input  logic              i_prog_rst_n,
  input  logic              i_start,
  input  logic              i_verify,
  input  logic [WORD_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic              o_prog_in,
  output logic              o_prog_en,
  input  logic              i_prog_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [7:0]        o_crc
);
  localparam int NW     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BCNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(NW + 1);
  localparam int SCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READBACK, S_FINISH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_hold;
  logic                r_hold_vld;
  logic [WORD_W-1:0]   r_sh;
  logic [SCNT_W-1:0]   r_sh_cnt;    // unsent bits left in r_sh
  logic [WCNT_W-1:0]   r_words;     // words accepted this load
  logic [BCNT_W-1:0]   r_bits;      // shifts done in the current phase
  logic [7:0]          r_crc;
  logic [7:0]          r_rb_crc;
  logic                r_err;
  logic                r_verify;
  logic                r_prog_en;
  logic                r_prog_in;

  logic w_hs;
  logic w_start;
  logic w_emit;
  logic w_from_hold;
  logic w_load_done;
  logic w_rb_last;
  logic w_bit;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_ff @(posedge i_prog_clk or negedge i_prog_rst_n) begin
    if (!i_prog_rst_n) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_s_ready   = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_prog_in   = r_prog_in;
    w_start     = 1'b0;
    w_emit      = 1'b0;
    w_from_hold = 1'b0;
    w_load_done = 1'b0;
    w_rb_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        o_s_ready = !r_hold_vld && (r_words != WCNT_W'(NW));
        // The final shift has been on the chain for a cycle; leave LOAD now.
        if (r_bits == BCNT_W'(CHAIN_LEN)) begin
          w_load_done = 1'b1;
          w_state_nxt = r_verify ? S_READBACK : S_FINISH;
        end else if (r_sh_cnt != '0) begin
          w_emit = 1'b1;
        end else if (r_hold_vld) begin
          // Emitting bit 0 straight from the holding register keeps word
          // boundaries bubble-free.
          w_emit      = 1'b1;
          w_from_hold = 1'b1;
        end
      end
      S_READBACK: begin
        o_prog_in = i_prog_out;
        if (r_bits == BCNT_W'(CHAIN_LEN - 1)) begin
          w_rb_last   = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hs      = i_s_valid && o_s_ready;
  assign w_bit     = w_from_hold ? r_hold[0] : r_sh[0];
  assign o_prog_en = r_prog_en;
  assign o_err     = r_err;
  assign o_crc     = r_crc;

  always_ff @(posedge i_prog_clk or negedge i_prog_rst_n) begin
    if (!i_prog_rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_sh       <= '0;
      r_sh_cnt   <= '0;
      r_words    <= '0;
      r_bits     <= '0;
      r_crc      <= 8'h00;
      r_rb_crc   <= 8'h00;
      r_err      <= 1'b0;
      r_verify   <= 1'b0;
      r_prog_en  <= 1'b0;
      r_prog_in  <= 1'b0;
    end else begin
      if (w_start) begin
        r_verify   <= i_verify;
        r_err      <= 1'b0;
        r_crc      <= 8'h00;
        r_bits     <= '0;
        r_words    <= '0;
        r_hold_vld <= 1'b0;
        r_sh_cnt   <= '0;
      end
      // A handshake cannot coincide with draining the holding register:
      // s_ready requires it to be empty.
      if (w_hs) begin
        r_hold     <= i_s_data;
        r_hold_vld <= 1'b1;
        r_words    <= r_words + 1'b1;
      end else if (w_from_hold) begin
        r_hold_vld <= 1'b0;
      end
      if (w_emit) begin
        r_prog_in <= w_bit;
        r_bits    <= r_bits + 1'b1;
        r_crc     <= crc8_step(r_crc, w_bit);
        if (w_from_hold) begin
          r_sh     <= r_hold >> 1;
          r_sh_cnt <= SCNT_W'(WORD_W - 1);
        end else begin
          r_sh     <= r_sh >> 1;
          r_sh_cnt <= r_sh_cnt - 1'b1;
        end
      end
      // Leftover bits of a partial last word are dropped here.
      if (w_load_done) begin
        r_bits    <= '0;
        r_rb_crc  <= 8'h00;
        r_sh_cnt  <= '0;
        r_prog_in <= 1'b0;
      end
      if (r_state == S_READBACK) begin
        r_bits   <= r_bits + 1'b1;
        r_rb_crc <= crc8_step(r_rb_crc, i_prog_out);
      end
      if (w_rb_last) r_err <= (crc8_step(r_rb_crc, i_prog_out) != r_crc);
      r_prog_en <= w_emit || (w_load_done && r_verify) ||
                   ((r_state == S_READBACK) && !w_rb_last);
    end
  end
endmodule

// File: tb/tb_sb_config_loader.sv
`timescale 1ns/1ps
module tb_sb_config_loader;
  localparam int L  = 32;
  localparam int W  = 8;
  localparam int NW = 4;
  localparam int LB = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, verify = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, prog_in, prog_en, prog_out, busy, done, err;
  logic [7:0] crc;
  logic [L-1:0] chain = '0;
  logic       flip_req = 1'b0;

  logic        b_start = 1'b0, b_verify = 1'b0, b_s_valid = 1'b0;
  logic [7:0]  b_s_data = 8'h00;
  logic        b_s_ready, b_prog_in, b_prog_en, b_prog_out, b_busy, b_done, b_err;
  logic [7:0]  b_crc;
  logic [LB-1:0] b_chain = '0;

  sb_config_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .i_prog_clk(clk), .i_prog_rst_n(rst_n), .i_start(start), .i_verify(verify),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_prog_in(prog_in), .o_prog_en(prog_en), .i_prog_out(prog_out),
    .o_busy(busy), .o_done(done), .o_err(err), .o_crc(crc));

  sb_config_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
    .i_prog_clk(clk), .i_prog_rst_n(rst_n), .i_start(b_start), .i_verify(b_verify),
    .i_s_data(b_s_data), .i_s_valid(b_s_valid), .o_s_ready(b_s_ready),
    .o_prog_in(b_prog_in), .o_prog_en(b_prog_en), .i_prog_out(b_prog_out),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_crc(b_crc));

  // Tile chain models: shift toward bit 0, tail is bit 0.
  assign prog_out   = chain[0];
  assign b_prog_out = b_chain[0];
  always @(posedge clk) begin
    logic [L-1:0] nxt;
    nxt = prog_en ? {prog_in, chain[L-1:1]} : chain;
    if (flip_req) nxt[5] = ~nxt[5];
    chain <= nxt;
  end
  always @(posedge clk) if (b_prog_en) b_chain <= {b_prog_in, b_chain[LB-1:1]};

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8_bits(input logic [63:0] bits, input int n);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Reference model state
  bit         m_op = 0, m_pend = 0, m_ver = 0, m_inj = 0, m_cont = 0;
  bit         p_ver = 0, p_inj = 0, p_cont = 0;
  bit         inj_req = 0;
  int         mode_req = 0;
  int         ld = 0, rb = 0, acc_n = 0, op_cyc = 0, first_hs = -1;
  logic [L-1:0] m_img = '0, m_exp_rb = '0;
  logic [7:0] m_crc = 8'h00;
  logic       m_err = 1'b0, m_exp_err;

  always @(negedge clk) begin
    flip_req = 1'b0;
    if (!rst_n) begin
      m_op = 0; m_pend = 0; m_err = 1'b0; m_crc = 8'h00; ld = 0;
      chk("reset_outputs", {s_ready, prog_in, prog_en, busy, done, err, crc}, 0);
    end else begin
      if (m_pend) begin
        m_pend = 0; m_op = 1; op_cyc = 0; ld = 0; rb = 0; acc_n = 0;
        first_hs = -1; m_img = '0; m_err = 1'b0;
        m_ver = p_ver; m_inj = p_inj; m_cont = p_cont;
      end
      if (!m_op) begin
        chk("idle_ctl", {busy, s_ready, prog_en, done}, 0);
        chk("idle_err", err, m_err);
        chk("idle_crc", crc, m_crc);
        if (start) begin
          m_pend = 1; p_ver = verify; p_inj = inj_req && verify; p_cont = (mode_req == 0);
        end
      end else begin
        chk("busy", busy, 1);
        if (op_cyc == 0) begin
          chk("start_ready", s_ready, 1);
          chk("start_crc", crc, 0);
        end
        if (ld < L) begin
          chk("load_done_low", done, 0);
          chk("load_err_low", err, 0);
          if (acc_n >= NW) chk("ready_after_nw", s_ready, 0);
          if (prog_en) begin
            if (ld == 0) chk("first_shift_lat", op_cyc, first_hs + 2);
            if (ld >= acc_n * W) chk("shift_unaccepted", ld, acc_n * W);
            else chk("load_bit", prog_in, m_img[ld]);
            ld++;
          end else if (m_cont && ld > 0) begin
            chk("load_gap", prog_en, 1);
          end
          if (s_valid && s_ready) begin
            if (first_hs < 0) first_hs = op_cyc;
            if (acc_n < NW) m_img[acc_n*W +: W] = s_data;
            acc_n++;
          end
          m_exp_rb = m_img ^ (m_inj ? 32'h40 : 32'h0);
        end else if (m_ver && rb < L) begin
          chk("rb_en", prog_en, 1);
          chk("rb_loop", prog_in, prog_out);
          chk("rb_chain_bit", prog_out, m_exp_rb[rb]);
          chk("rb_ctl_low", {done, s_ready, err}, 0);
          if (rb == 0 && m_inj) flip_req = 1'b1;
          rb++;
        end else begin
          m_exp_err = m_ver ? (crc8_bits(m_exp_rb, L) != crc8_bits(m_img, L)) : 1'b0;
          chk("done", done, 1);
          chk("done_en", {prog_en, s_ready}, 0);
          chk("final_crc", crc, crc8_bits(m_img, L));
          chk("final_err", err, m_exp_err);
          if (!m_inj) chk("final_chain", chain, m_img);
          m_crc = crc8_bits(m_img, L);
          m_err = m_exp_err;
          m_op  = 0;
        end
        op_cyc++;
      end
    end
  end

  task automatic do_op(input bit ver, input int mode, input bit inj, input int rst_at,
                       input bit use_img, input logic [31:0] img_in);
    int  wi, cnt;
    bit  hs, dn;
    @(posedge clk); #1;
    start = 1'b1; verify = ver; inj_req = inj; mode_req = mode;
    @(posedge clk); #1;
    start = 1'b0; verify = 1'($urandom_range(0, 1));
    wi = 0; cnt = 0; dn = 0;
    s_data  = use_img ? img_in[7:0] : 8'($urandom);
    s_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!dn) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      dn = done;
      if (rst_at > 0 && ld >= rst_at) begin
        #1 rst_n = 1'b0;
        #1 chk("async_rst_out", {s_ready, prog_in, prog_en, busy, done, err, crc}, 0);
        s_valid = 1'b0;
        start   = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (cnt >= 2000) begin
        chk("op_timeout", dn, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cnt++;
      if (hs) begin
        wi++;
        s_data = (wi < NW) ? (use_img ? img_in[wi*8 +: 8] : 8'($urandom)) : 8'hA5;
      end
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = !s_valid;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      // A start pulse in mid-operation must be ignored.
      start  = (cnt == 5);
      verify = (cnt == 5) ? !ver : verify;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int  b_acc, b_en;
    bit  b_got;
    bit  rv;
    chk("model_pin_crc32", crc8_bits(64'h80000001, 32), 8'h36);
    chk("model_pin_crc1", crc8_bits(64'h1, 1), 8'h07);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(1'b0, 0, 1'b0, 0, 1'b1, 32'h80000001);
    chk("t1_chain", chain, 32'h80000001);
    chk("t1_crc", crc, 8'h36);
    chk("t1_err", err, 0);

    do_op(1'b1, 0, 1'b0, 0, 1'b1, 32'h80000001);
    chk("t2_chain", chain, 32'h80000001);
    chk("t2_crc", crc, 8'h36);
    chk("t2_err", err, 0);

    do_op(1'b1, 0, 1'b1, 0, 1'b1, 32'h80000001);
    chk("t3_err", err, 1);
    repeat (5) @(posedge clk);
    #1 chk("t3_err_sticky", err, 1);

    do_op(1'b1, 1, 1'b0, 0, 1'b0, 32'h0);
    do_op(1'b0, 0, 1'b0, 10, 1'b0, 32'h0);
    do_op(1'b1, 0, 1'b0, 0, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      rv = 1'($urandom_range(0, 1));
      do_op(rv, $urandom_range(0, 2), rv & 1'($urandom_range(0, 1)), 0, 1'b0, 32'h0);
    end

    // Short chain with a partial last word.
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0; b_s_valid = 1'b1; b_s_data = 8'hFF;
    b_acc = 0; b_en = 0; b_got = 0;
    for (int c = 0; c < 200 && !b_got; c++) begin
      @(negedge clk);
      if (b_acc >= 3) chk("b_ready_after_3", b_s_ready, 0);
      if (b_s_valid && b_s_ready) b_acc++;
      if (b_prog_en) b_en++;
      if (b_done) b_got = 1;
    end
    b_s_valid = 1'b0;
    chk("b_done_seen", b_got, 1);
    chk("b_words", b_acc, 3);
    chk("b_shifts", b_en, 20);
    chk("b_chain", b_chain, 20'hFFFFF);
    chk("b_crc", b_crc, crc8_bits(64'hFFFFF, 20));
    chk("b_err", b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sb_config_loader.md
# sb_config_loader

Configuration-chain programmer for switch-box tiles. Accepts a configuration image as a stream of words, serialises it LSB-first onto the tile chain (`prog_in`/`prog_en`), and optionally reads the chain back non-destructively (recirculating `prog_out` into `prog_in`) to check a CRC-8 computed during load. It sits between the bitstream source and the first switch-box in the chain; all chained tiles share `prog_clk`.

## Interface
- `CHAIN_LEN`, 32: total configuration bits in the chain, ≥ 2.
- `WORD_W`, 8: input word width, ≥ 1; words per load `NW = ceil(CHAIN_LEN/WORD_W)`.
- `prog_clk`  in  1  sole clock; everything is rising-edge.
- `prog_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  1-cycle request; sampled only in IDLE.
- `verify`  in  1  sampled with `start`; 1 means run readback after load.
- `s_data`  in  WORD_W  configuration word, bit 0 shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader can take a word.
- `prog_in`  out  1  serial data to chain head.
- `prog_en`  out  1  chain shift enable, one bit per high cycle.
- `prog_out`  in  1  serial data from chain tail.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  1-cycle pulse at end of operation.
- `err`  out  1  readback CRC mismatch; sticky until next accepted `start`.
- `crc`  out  8  CRC-8 of the loaded bits, held until next `start`.

## Operation
- States: IDLE, LOAD, READBACK, FINISH.
- IDLE: `s_ready`=0, `prog_en`=0. On `start`=1, latch `verify`, clear `err`, clear `crc` to 0x00, clear bit counter, go to LOAD.
- LOAD: 1-word holding register plus 1-word shift register. `s_ready`=1 while holding register is empty and fewer than NW words have been accepted. A handshake is `s_valid && s_ready`.
- Each cycle the shift register holds an unsent bit: `prog_en`=1, `prog_in`=that bit, bit counter +1, CRC updated with the bit. No bit available: `prog_en`=0 (stall), chain untouched.
- Word bits are sent 0..WORD_W-1. In the last word, bits beyond `CHAIN_LEN` are discarded and never shifted.
- After exactly `CHAIN_LEN` shifts: go to READBACK if `verify`, else FINISH. Words offered beyond NW are not accepted.
- Bit order: image bit k is the k-th bit shifted. After load, chain register bit k equals image bit k (tile shifts toward bit 0).
- READBACK: `CHAIN_LEN` consecutive cycles with `prog_en`=1 and `prog_in` = `prog_out` (combinational). The chain rotates once and returns to its loaded contents. Readback CRC is computed over `prog_out` in the same cycles. At end, `err` = (readback CRC ≠ `crc`). Go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- CRC-8: polynomial 0x07, init 0x00, bit-serial, no reflection, no final XOR. Per bit b: `fb = crc[7]^b`; `crc = {crc[6:0],0} ^ (fb ? 0x07 : 0)`.
- `start` outside IDLE is ignored.
- Reset at any time: back to IDLE, all outputs at reset values, counters and buffers cleared. Chain contents are undefined and must be reloaded.

## Timing
- Reset values: `s_ready`=0, `prog_in`=0, `prog_en`=0, `busy`=0, `done`=0, `err`=0, `crc`=0x00.
- `prog_en` and `prog_in` are registered in LOAD. Only `prog_in` in READBACK is combinational.
- `start` sampled at edge T: `busy`=1 and `s_ready`=1 from T+1.
- First handshake at edge H: first `prog_en`=1 cycle begins after H+1.
- With `s_valid` held high, all `CHAIN_LEN` load shifts are back-to-back with no bubbles. The holding register refills during the shift of the previous word.
- Simultaneous handshake and last-bit shift of the current word: the next word's bit 0 follows in the next cycle.
- Operation lengths:
  - No-verify with continuous input: `done` pulses 1 cycle after the last load shift.
  - Verify: READBACK starts the cycle after the last load shift and lasts exactly `CHAIN_LEN` cycles. `done` and the final `err` appear the cycle after.
- `crc` is final when `done` pulses.

## Test plan
- CHAIN_LEN=32, WORD_W=8, verify=0, words 0x01,0x00,0x00,0x80 streamed continuously -> exactly 32 `prog_en` cycles with no gaps, chain register = 0x80000001, `done` pulse, `err`=0.
- Same image with verify=1 -> 32 further `prog_en` cycles with `prog_in`=`prog_out`, chain still 0x80000001, `crc` equal to the software CRC-8 of the 32 bits, `err`=0.
- Verify=1 with the bench forcing chain bit 5 to flip during readback -> `err`=1 at `done`, stays 1 until the next `start`.
- CHAIN_LEN=20, WORD_W=8, words 0xFF,0xFF,0xFF -> 20 shifts only, upper nibble of the third word not shifted, `s_ready` low after 3 words, chain = 0xFFFFF.
- `s_valid` toggled 1-0-1 every other cycle -> `prog_en` gaps occur only while the buffer is empty; total shifts = CHAIN_LEN; final image correct.
- `prog_rst_n` pulsed low mid-LOAD at shift 10, then `start` reissued -> outputs at reset values immediately, second load completes correctly; `start` pulsed while busy -> ignored.
